div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high (`ResetEnable), sampled on posedge clock.
REQ-004 signed_div_input  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU).
REQ-005 opdata1_input  input  `RegisterBus  dividend.
REQ-006 opdata2_input  input  `RegisterBus  divisor.
REQ-007 start_input  input  1  `DivStart requests or holds an operation; `DivStop releases it.
REQ-008 annul_input  input  1  cancels an operation in progress (flush).
REQ-009 result_output  output  `DoubleRegisterBus  {remainder[63:32], quotient[31:0]}, registered.
REQ-010 ready_output  output  1  `DivResultReady when result_output is valid, registered.
REQ-011 stall_request_output  output  1  combinational, equal to start_input AND NOT ready_output; drives the stop_all stall request for EX.

Function
REQ-012 FSM states SHALL be FREE (`DivFree), BYZERO (`DivByZero), ON (`DivOn) and END (`DivEnd).
REQ-013 In FREE, when start_input=1, annul_input=0 and opdata2_input=0, the FSM SHALL go to BYZERO.
REQ-014 In FREE, when start_input=1, annul_input=0 and opdata2_input!=0, the FSM SHALL go to ON.
  - Latch both operands, counter=0, sign flags.
  - When signed, negative operands are latched as two's-complement magnitudes.
  - Working register (65 bits) = {32'b0, |dividend|, 1'b0}.
REQ-015 In FREE with annul_input=1 or start_input=0, the FSM SHALL stay in FREE with ready_output=0.
REQ-016 After the FREE edge, input operand changes SHALL be ignored (operands are latched).
REQ-017 In ON with counter<32, each cycle SHALL compute diff = work[63:32] - divisor (33-bit).
  - diff negative: work <= {work[63:0],1'b0}.
  - Otherwise: work <= {diff[31:0], work[31:0], 1'b1}.
  - counter++.
REQ-018 In ON with counter==32, the FSM SHALL apply sign correction, load result_output, set ready_output=1 and go to END.
  - quotient = work[31:0], negated if signed and the operand signs differ.
  - remainder = work[64:33], negated if signed and the dividend is negative.
REQ-019 annul_input=1 in ON SHALL return the FSM to FREE with counter=0, ready_output=0 and result_output=0; the annul has priority over iteration.
REQ-020 BYZERO SHALL go to END on the next edge with result_output=0 and ready_output=1.
REQ-021 In END, the block SHALL hold result_output and ready_output while start_input=1; start_input=0 SHALL return to FREE with ready_output=0 and result_output=0 on that edge.
REQ-022 annul_input in END and BYZERO SHALL be ignored; only start_input releases END.
REQ-023 Latency SHALL be 34 edges from the start-sampling edge to ready_output=1 (1 accept + 32 iterations + 1 finalize); divide by zero takes 2 edges.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0, without trapping.
REQ-025 A new operation SHALL be accepted no earlier than the edge after the return to FREE.

Reset
REQ-026 On reset, on the same edge, the FSM SHALL enter FREE with counter=0, work register=0, result_output=`ZeroWord pair, ready_output=`DivResultNotReady.
REQ-027 Reset SHALL take priority over start_input and annul_input in every state, including mid-operation.

Structure
REQ-028 The shared defines.v file SHALL hold: `DivFree, `DivByZero, `DivOn, `DivEnd, `DivStart, `DivStop, `DivResultReady, `DivResultNotReady, plus the existing `RegisterBus, `DoubleRegisterBus, `ZeroWord and `ResetEnable.
REQ-029 The block SHALL be a single module with no sub-modules; the 33-bit subtract is inline.
REQ-030 The EX stage SHALL hold start_input high until ready_output, then drop it for one cycle.

Verification
REQ-031 Unsigned 100/7 with start held -> ready_output rises 34 cycles later; result_output = {0x00000002, 0x0000000E}; stall_request_output high for exactly 34 cycles.
REQ-032 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_output = {0xFFFFFFFF, 0xFFFFFFFD}.
REQ-033 Unsigned 0xFFFFFFFF/1 -> {0x00000000, 0xFFFFFFFF}; signed 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-034 Divisor 0 -> ready_output after 2 edges, result_output = 0; dropping start returns to FREE and ready_output=0.
REQ-035 annul_input pulse at iteration 10 -> FREE next edge, ready_output never asserts; a following 9/3 operation yields {0, 3} after 34 cycles.
REQ-036 reset asserted at iteration 20 -> all outputs 0 next edge; a subsequent operation completes correctly.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states, handshake levels
// and bus widths, plus a small two's-complement helper.
package div_ctrl_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   localparam logic RESET_ENABLE         = 1'b1;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   localparam logic [DATA_W-1:0] ZERO_WORD = '0;

   function automatic logic [DATA_W-1:0] neg_word(input logic [DATA_W-1:0] v);
      return ~v + 1'b1;
   endfunction

endpackage

// File: rtl/div_ctrl.sv
// Radix-2 restoring divider (DIV/DIVU): 1 accept cycle, 32 shift/subtract
// iterations and 1 sign-correction cycle; result held until start drops.
module div_ctrl
   import div_ctrl_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  signed_div_input,
   input  logic [DATA_W-1:0]     opdata1_input,
   input  logic [DATA_W-1:0]     opdata2_input,
   input  logic                  start_input,
   input  logic                  annul_input,
   output logic [2*DATA_W-1:0]   result_output,
   output logic                  ready_output,
   output logic                  stall_request_output
);

   div_state_e                state_q;
   logic [5:0]                cnt_q;
   logic [2*DATA_W:0]         work_q;
   logic [DATA_W-1:0]         divisor_q;
   logic                      neg_quot_q;
   logic                      neg_rem_q;
   logic [2*DATA_W-1:0]       result_q;
   logic                      ready_q;

   logic [DATA_W-1:0]         dvd_mag_d;
   logic [DATA_W-1:0]         dsr_mag_d;
   logic signed [DATA_W:0]    diff_d;
   logic [2*DATA_W:0]         work_d;
   logic [DATA_W-1:0]         quot_d;
   logic [DATA_W-1:0]         rem_d;

   // Operands are stored as magnitudes; signs are reapplied at the end.
   assign dvd_mag_d = (signed_div_input && opdata1_input[DATA_W-1]) ?
                      neg_word(opdata1_input) : opdata1_input;
   assign dsr_mag_d = (signed_div_input && opdata2_input[DATA_W-1]) ?
                      neg_word(opdata2_input) : opdata2_input;

   assign diff_d = $signed({1'b0, work_q[2*DATA_W-1:DATA_W]}) - $signed({1'b0, divisor_q});
   assign work_d = diff_d[DATA_W] ? {work_q[2*DATA_W-1:0], 1'b0}
                                  : {diff_d[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};

   assign quot_d = neg_quot_q ? neg_word(work_q[DATA_W-1:0]) : work_q[DATA_W-1:0];
   assign rem_d  = neg_rem_q  ? neg_word(work_q[2*DATA_W:DATA_W+1]) : work_q[2*DATA_W:DATA_W+1];

   always_ff @(posedge clock) begin
      if (reset == RESET_ENABLE) begin
         state_q    <= DIV_FREE;
         cnt_q      <= '0;
         work_q     <= '0;
         divisor_q  <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         result_q   <= {ZERO_WORD, ZERO_WORD};
         ready_q    <= DIV_RESULT_NOT_READY;
      end else begin
         case (state_q)
            DIV_FREE: begin
               result_q <= {ZERO_WORD, ZERO_WORD};
               ready_q  <= DIV_RESULT_NOT_READY;
               if (start_input == DIV_START && !annul_input) begin
                  if (opdata2_input == ZERO_WORD) begin
                     state_q <= DIV_BYZERO;
                  end else begin
                     state_q    <= DIV_ON;
                     cnt_q      <= '0;
                     work_q     <= {ZERO_WORD, dvd_mag_d, 1'b0};
                     divisor_q  <= dsr_mag_d;
                     neg_quot_q <= signed_div_input & (opdata1_input[DATA_W-1] ^ opdata2_input[DATA_W-1]);
                     neg_rem_q  <= signed_div_input & opdata1_input[DATA_W-1];
                  end
               end
            end
            DIV_BYZERO: begin
               state_q  <= DIV_END;
               result_q <= {ZERO_WORD, ZERO_WORD};
               ready_q  <= DIV_RESULT_READY;
            end
            DIV_ON: begin
               if (annul_input) begin
                  state_q  <= DIV_FREE;
                  cnt_q    <= '0;
                  result_q <= {ZERO_WORD, ZERO_WORD};
                  ready_q  <= DIV_RESULT_NOT_READY;
               end else if (cnt_q != 6'd32) begin
                  work_q <= work_d;
                  cnt_q  <= cnt_q + 6'd1;
               end else begin
                  state_q  <= DIV_END;
                  cnt_q    <= '0;
                  result_q <= {rem_d, quot_d};
                  ready_q  <= DIV_RESULT_READY;
               end
            end
            DIV_END: begin
               if (start_input == DIV_STOP) begin
                  state_q  <= DIV_FREE;
                  result_q <= {ZERO_WORD, ZERO_WORD};
                  ready_q  <= DIV_RESULT_NOT_READY;
               end
            end
            default: state_q <= DIV_FREE;
         endcase
      end
   end

   assign result_output        = result_q;
   assign ready_output         = ready_q;
   assign stall_request_output = start_input & ~ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: expected results come from native integer
// division and are queued at issue, then checked when ready_output rises.
module tb_div_ctrl;

   logic        clock;
   logic        reset;
   logic        signed_div_input;
   logic [31:0] opdata1_input;
   logic [31:0] opdata2_input;
   logic        start_input;
   logic        annul_input;
   logic [63:0] result_output;
   logic        ready_output;
   logic        stall_request_output;

   int checks   = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   div_ctrl dut (
      .clock                (clock),
      .reset                (reset),
      .signed_div_input     (signed_div_input),
      .opdata1_input        (opdata1_input),
      .opdata2_input        (opdata2_input),
      .start_input          (start_input),
      .annul_input          (annul_input),
      .result_output        (result_output),
      .ready_output         (ready_output),
      .stall_request_output (stall_request_output)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
      int q;
      int r;
      if (b == 32'd0) return 64'd0;
      if (!s) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r[31:0], q[31:0]};
   endfunction

   task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit scramble);
      int cyc;
      int stalls;
      int lat_exp;
      logic [63:0] exp;
      lat_exp = (b == 32'd0) ? 2 : 34;
      @(negedge clock);
      signed_div_input = s;
      opdata1_input    = a;
      opdata2_input    = b;
      start_input      = 1'b1;
      annul_input      = 1'b0;
      exp_q.push_back(model(s, a, b));
      #1;
      cyc    = 0;
      stalls = 0;
      while (ready_output !== 1'b1 && cyc < 100) begin
         if (stall_request_output === 1'b1) stalls++;
         @(negedge clock);
         cyc++;
         if (scramble && cyc == 1) begin
            opdata1_input    = $urandom;
            opdata2_input    = $urandom;
            signed_div_input = ~s;
         end
      end
      checks++;
      if (cyc != lat_exp) begin
         failures++;
         $display("FAIL latency %h/%h: got %0d edges expected %0d", a, b, cyc, lat_exp);
      end
      checks++;
      if (stalls != lat_exp) begin
         failures++;
         $display("FAIL stall_cycles %h/%h: got %0d expected %0d", a, b, stalls, lat_exp);
      end
      exp = exp_q.pop_front();
      checks++;
      if (result_output !== exp) begin
         failures++;
         $display("FAIL result s=%0b %h/%h: got %h expected %h", s, a, b, result_output, exp);
      end
      annul_input = 1'b1;
      @(negedge clock);
      checks++;
      if (ready_output !== 1'b1 || result_output !== exp) begin
         failures++;
         $display("FAIL end_hold: got ready=%0b res=%h expected ready=1 res=%h", ready_output, result_output, exp);
      end
      annul_input = 1'b0;
      start_input = 1'b0;
      @(negedge clock);
      checks++;
      if (ready_output !== 1'b0 || result_output !== 64'd0) begin
         failures++;
         $display("FAIL release: got ready=%0b res=%h expected ready=0 res=0", ready_output, result_output);
      end
   endtask

   task automatic test_reset();
      reset            = 1'b1;
      start_input      = 1'b1;
      annul_input      = 1'b0;
      signed_div_input = 1'b0;
      opdata1_input    = 32'd50;
      opdata2_input    = 32'd5;
      repeat (3) @(negedge clock);
      checks++;
      if (ready_output !== 1'b0 || result_output !== 64'd0) begin
         failures++;
         $display("FAIL reset_state: got ready=%0b res=%h expected ready=0 res=0", ready_output, result_output);
      end
      start_input = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (ready_output !== 1'b0 || stall_request_output !== 1'b0) begin
         failures++;
         $display("FAIL idle: got ready=%0b stall=%0b expected 0 0", ready_output, stall_request_output);
      end
   endtask

   task automatic test_unsigned();
      do_op(1'b0, 32'd100, 32'd7, 1'b0);
      do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
      do_op(1'b0, 32'd5, 32'd9, 1'b0);
   endtask

   task automatic test_signed();
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
      do_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0);
   endtask

   task automatic test_byzero();
      do_op(1'b0, 32'd1234, 32'd0, 1'b0);
      do_op(1'b1, 32'h8000_0000, 32'd0, 1'b0);
   endtask

   task automatic test_operand_latch();
      do_op(1'b0, 32'd1000, 32'd13, 1'b1);
      do_op(1'b1, 32'hFFFF_0000, 32'd77, 1'b1);
   endtask

   task automatic test_annul();
      bit seen_ready;
      seen_ready = 1'b0;
      @(negedge clock);
      signed_div_input = 1'b0;
      opdata1_input    = 32'd1000;
      opdata2_input    = 32'd3;
      start_input      = 1'b1;
      repeat (11) begin
         @(negedge clock);
         if (ready_output === 1'b1) seen_ready = 1'b1;
      end
      annul_input = 1'b1;
      @(negedge clock);
      annul_input = 1'b0;
      start_input = 1'b0;
      checks++;
      if (ready_output !== 1'b0 || result_output !== 64'd0) begin
         failures++;
         $display("FAIL annul: got ready=%0b res=%h expected ready=0 res=0", ready_output, result_output);
      end
      repeat (40) begin
         @(negedge clock);
         if (ready_output === 1'b1) seen_ready = 1'b1;
      end
      checks++;
      if (seen_ready) begin
         failures++;
         $display("FAIL annul_no_ready: got ready asserted expected never");
      end
      do_op(1'b0, 32'd9, 32'd3, 1'b0);
   endtask

   task automatic test_reset_mid();
      @(negedge clock);
      signed_div_input = 1'b1;
      opdata1_input    = 32'hDEAD_BEEF;
      opdata2_input    = 32'h0000_1234;
      start_input      = 1'b1;
      repeat (21) @(negedge clock);
      reset       = 1'b1;
      start_input = 1'b0;
      @(negedge clock);
      checks++;
      if (ready_output !== 1'b0 || result_output !== 64'd0 || stall_request_output !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: got ready=%0b res=%h stall=%0b expected all 0",
                  ready_output, result_output, stall_request_output);
      end
      reset = 1'b0;
      do_op(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 8; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
         if (b == 32'd0) b = 32'd1;
         do_op(s, a, b, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_byzero();
      test_operand_latch();
      test_annul();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
